// File: rtl/hamming_corrector.sv
`default_nettype none
// ============================================================================
// Module   : hamming_corrector
// Purpose  : Two-stage Hamming(7,4) correction pipeline. It flips the bit
//            that the incoming syndrome points at and extracts the 4 data
//            bits. It also keeps saturating delivered-word and error counters.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_corrector #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_stats,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    input  logic [2:0]       in_syndrome,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [6:0]       out_code,
    output logic [2:0]       out_err_pos,
    output logic             out_err_flag,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Stage 1 (capture) registers
    logic             r_s1_valid;
    logic [6:0]       r_s1_code;
    logic [2:0]       r_s1_syndrome;

    // Stage 2 (output) registers
    logic             r_out_valid;
    logic [3:0]       r_out_data;
    logic [6:0]       r_out_code;
    logic [2:0]       r_out_err_pos;
    logic             r_out_err_flag;

    // Statistics
    logic [CNT_W-1:0] r_word_count;
    logic [CNT_W-1:0] r_err_count;

    // Pipeline control and correction datapath
    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_out_fire;
    logic [6:0]       w_flip_mask;
    logic [6:0]       w_corr_code;

    // Advance control: the output stage moves when it is empty or drained.
    // Stage 1 moves when it is empty or its word moves on. in_ready depends
    // only on registered valids and out_ready, so it never sees in_valid.
    always_comb begin
        w_s2_load  = !r_out_valid || out_ready;
        w_s1_load  = !r_s1_valid || w_s2_load;
        w_out_fire = r_out_valid && out_ready;
    end

    // Syndrome k (1..7) selects bit k-1. Syndrome 0 leaves the word unchanged.
    always_comb begin
        w_flip_mask = 7'b000_0000;
        case (r_s1_syndrome)
            3'd1:    w_flip_mask = 7'b000_0001;
            3'd2:    w_flip_mask = 7'b000_0010;
            3'd3:    w_flip_mask = 7'b000_0100;
            3'd4:    w_flip_mask = 7'b000_1000;
            3'd5:    w_flip_mask = 7'b001_0000;
            3'd6:    w_flip_mask = 7'b010_0000;
            3'd7:    w_flip_mask = 7'b100_0000;
            default: w_flip_mask = 7'b000_0000;
        endcase
        w_corr_code = r_s1_code ^ w_flip_mask;
    end

    // Stage 1: capture the incoming word and syndrome whenever the slot can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_code     <= 7'd0;
            r_s1_syndrome <= 3'd0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code     <= in_code;
                r_s1_syndrome <= in_syndrome;
            end
        end
    end

    // Stage 2: register the corrected word. Hold the outputs while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= 4'd0;
            r_out_code     <= 7'd0;
            r_out_err_pos  <= 3'd0;
            r_out_err_flag <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_code     <= w_corr_code;
                r_out_data     <= {w_corr_code[6], w_corr_code[5],
                                   w_corr_code[4], w_corr_code[2]};
                r_out_err_pos  <= r_s1_syndrome;
                r_out_err_flag <= (r_s1_syndrome != 3'd0);
            end
        end
    end

    // Saturating statistics. clear_stats overrides a same-cycle delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count <= '0;
            r_err_count  <= '0;
        end else if (clear_stats) begin
            r_word_count <= '0;
            r_err_count  <= '0;
        end else if (w_out_fire) begin
            if (r_word_count != c_cnt_max) begin
                r_word_count <= r_word_count + c_cnt_one;
            end
            if (r_out_err_flag && (r_err_count != c_cnt_max)) begin
                r_err_count <= r_err_count + c_cnt_one;
            end
        end
    end

    assign in_ready     = w_s1_load;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_code     = r_out_code;
    assign out_err_pos  = r_out_err_pos;
    assign out_err_flag = r_out_err_flag;
    assign word_count   = r_word_count;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_corrector.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_corrector
// Purpose  : Directed self-checking bench for hamming_corrector. It runs with
//            CNT_W=2 so that counter saturation is reached quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_corrector;

    localparam int CNT_W = 2;
    localparam logic [6:0] c_good = 7'b1010101;

    logic             clk;
    logic             rst;
    logic             clear_stats;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_code;
    logic [2:0]       in_syndrome;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [6:0]       out_code;
    logic [2:0]       out_err_pos;
    logic             out_err_flag;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    int n_assert;
    int n_fail;

    hamming_corrector #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_stats  (clear_stats),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .in_syndrome  (in_syndrome),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_code     (out_code),
        .out_err_pos  (out_err_pos),
        .out_err_flag (out_err_flag),
        .word_count   (word_count),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] codes [3];
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        clear_stats = 1'b0;
        in_valid    = 1'b0;
        in_code     = 7'd0;
        in_syndrome = 3'd0;
        out_ready   = 1'b1;
        codes[0]    = 7'h11;
        codes[1]    = 7'h22;
        codes[2]    = 7'h33;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        chk("rst_err_pos", 32'(out_err_pos), 32'd0);
        chk("rst_err_flag", 32'(out_err_flag), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Clean word: appears two edges after acceptance
        in_valid = 1'b1; in_code = c_good; in_syndrome = 3'd0;
        tick;
        in_valid = 1'b0;
        chk("clean_lat1_valid", 32'(out_valid), 32'd0);
        tick;
        chk("clean_valid", 32'(out_valid), 32'd1);
        chk("clean_code", 32'(out_code), 32'(c_good));
        chk("clean_data", 32'(out_data), 32'(4'b1011));
        chk("clean_pos", 32'(out_err_pos), 32'd0);
        chk("clean_flag", 32'(out_err_flag), 32'd0);
        tick;
        chk("clean_bubble", 32'(out_valid), 32'd0);
        chk("clean_wcnt", 32'(word_count), 32'd1);
        chk("clean_ecnt", 32'(err_count), 32'd0);

        // Single error in bit 4
        in_valid = 1'b1; in_code = 7'b1000101; in_syndrome = 3'd5;
        tick;
        in_valid = 1'b0;
        tick;
        chk("err_code", 32'(out_code), 32'(c_good));
        chk("err_data", 32'(out_data), 32'(4'b1011));
        chk("err_pos", 32'(out_err_pos), 32'd5);
        chk("err_flag", 32'(out_err_flag), 32'd1);
        tick;
        chk("err_wcnt", 32'(word_count), 32'd2);
        chk("err_ecnt", 32'(err_count), 32'd1);

        // Clear, then stream all 7 single-bit flips plus one clean word
        clear_stats = 1'b1;
        tick;
        clear_stats = 1'b0;
        chk("clr_wcnt", 32'(word_count), 32'd0);
        chk("clr_ecnt", 32'(err_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            in_code     = (i < 7) ? (c_good ^ (7'd1 << i)) : c_good;
            in_syndrome = (i < 7) ? 3'(i + 1) : 3'd0;
            chk("sweep_in_ready", 32'(in_ready), 32'd1);
            tick;
            if (i >= 1) begin
                chk("sweep_valid", 32'(out_valid), 32'd1);
                chk("sweep_code", 32'(out_code), 32'(c_good));
                chk("sweep_pos", 32'(out_err_pos), 32'(i));
            end
        end
        in_valid = 1'b0;
        tick;
        chk("sweep_last_valid", 32'(out_valid), 32'd1);
        chk("sweep_last_code", 32'(out_code), 32'(c_good));
        chk("sweep_last_pos", 32'(out_err_pos), 32'd0);
        chk("sweep_last_flag", 32'(out_err_flag), 32'd0);
        tick;
        chk("sweep_drained", 32'(out_valid), 32'd0);
        chk("sweep_wcnt_sat", 32'(word_count), 32'd3);
        chk("sweep_ecnt_sat", 32'(err_count), 32'd3);

        // Saturation: five errored words, and the counters must not wrap
        clear_stats = 1'b1;
        tick;
        clear_stats = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            in_code     = c_good ^ (7'd1 << i);
            in_syndrome = 3'(i + 1);
            tick;
        end
        in_valid = 1'b0;
        chk("sat3_wcnt", 32'(word_count), 32'd3);
        chk("sat3_ecnt", 32'(err_count), 32'd3);
        tick;
        tick;
        chk("sat5_wcnt", 32'(word_count), 32'd3);
        chk("sat5_ecnt", 32'(err_count), 32'd3);

        // clear_stats wins over a simultaneous delivery
        in_valid = 1'b1; in_code = 7'b1010100; in_syndrome = 3'd1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("clrhs_valid", 32'(out_valid), 32'd1);
        clear_stats = 1'b1;
        tick;
        clear_stats = 1'b0;
        chk("clrhs_wcnt", 32'(word_count), 32'd0);
        chk("clrhs_ecnt", 32'(err_count), 32'd0);

        // Backpressure: two words held, third waits, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_syndrome = 3'd0; in_code = codes[0];
        chk("bp_rdy0", 32'(in_ready), 32'd1);
        tick;
        in_code = codes[1];
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        tick;
        in_code = codes[2];
        chk("bp_rdy2_low", 32'(in_ready), 32'd0);
        chk("bp_hold_code", 32'(out_code), 32'(codes[0]));
        tick;
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_code2", 32'(out_code), 32'(codes[0]));
        chk("bp_hold_data", 32'(out_data), 32'(4'b0010));
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold_wcnt", 32'(word_count), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("bp_word_b", 32'(out_code), 32'(codes[1]));
        tick;
        chk("bp_word_c", 32'(out_code), 32'(codes[2]));
        chk("bp_word_c_valid", 32'(out_valid), 32'd1);
        tick;
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_wcnt", 32'(word_count), 32'd3);

        // Asynchronous reset mid-stream, with no clock edge
        clear_stats = 1'b1;
        tick;
        clear_stats = 1'b0;
        in_valid = 1'b1; in_code = c_good; in_syndrome = 3'd0;
        tick;
        tick;
        tick;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_wcnt", 32'(word_count), 32'd1);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_wcnt", 32'(word_count), 32'd0);
        chk("ar_ecnt", 32'(err_count), 32'd0);
        tick;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_after_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_code = 7'b1010001; in_syndrome = 3'd3;
        tick;
        in_valid = 1'b0;
        chk("ar_new_lat1", 32'(out_valid), 32'd0);
        tick;
        chk("ar_new_valid", 32'(out_valid), 32'd1);
        chk("ar_new_code", 32'(out_code), 32'(c_good));
        chk("ar_new_pos", 32'(out_err_pos), 32'd3);
        tick;
        chk("ar_no_stale", 32'(out_valid), 32'd0);
        chk("ar_new_ecnt", 32'(err_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_corrector.md
Name: hamming_corrector

Overview:
Pipelined Hamming(7,4) correction stage. It sits directly downstream of the syndrome calculator. It takes the received 7-bit word plus its 3-bit syndrome, flips the single bit the syndrome points to, and extracts the 4 data bits. It also keeps saturating word and error counters for the display/debug logic. Valid/ready handshakes are used on both sides.

Parameters:
CNT_W, 8, width of the word and error statistics counters (saturating).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
clear_stats  input  1  synchronous clear of both counters
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_code  input  7  received word [6:0], possibly with one bit flipped
in_syndrome  input  3  {c2,c1,c0} syndrome for in_code
out_valid  output  1  corrected result valid
out_ready  input  1  downstream accepts the result
out_data  output  4  corrected data {b6,b5,b4,b2}
out_code  output  7  corrected codeword
out_err_pos  output  3  syndrome value; 0 means no error, k means bit k-1 was flipped
out_err_flag  output  1  1 when syndrome is non-zero
word_count  output  CNT_W  number of results delivered
err_count  output  CNT_W  number of delivered results with err_flag=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all pipeline valids 0; out_valid=0; out_data, out_code, out_err_pos, out_err_flag, word_count and err_count all 0. in_ready=1 once reset is deasserted.
- Reset mid-operation: any words in flight are discarded and never appear on the output.
- Bit/syndrome mapping, fixed:
  - syndrome 1 -> bit0, 2 -> bit1, 3 -> bit2, 4 -> bit3, 5 -> bit4, 6 -> bit5, 7 -> bit6.
  - Syndrome 0 -> no flip.
  - Parity bits are b0, b1, b3; data bits are b6, b5, b4, b2.
- Stage 1 (capture): registers in_code and in_syndrome together with s1_valid when in_valid && in_ready.
- Stage 2 (correct): computes a one-hot flip mask from the stage-1 syndrome, XORs it into the code, and registers out_code, out_data, out_err_pos, out_err_flag and out_valid.
- Advance rules:
  - Stage 2 loads when (!out_valid || out_ready).
  - Stage 1 loads when (!s1_valid || stage-2 loads).
  - in_ready equals the stage-1 load condition and is purely combinational from the registered valids and out_ready.
  - There is no combinational path from in_valid to in_ready.
- Latency: a word accepted in cycle N presents out_valid in cycle N+2 when not stalled.
- Throughput: one word per cycle while out_ready=1.
- Stall: with out_ready=0, at most 2 words are held (stage 1 plus output). in_ready drops the cycle after stage 1 fills. Outputs are held stable while out_valid && !out_ready.
- Bubbles: if stage 1 is empty when stage 2 loads, out_valid goes 0 after the handshake.
- Counters:
  - On each out_valid && out_ready, word_count increments, and err_count increments if out_err_flag=1.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - clear_stats zeroes both counters on the next edge and takes priority over a simultaneous increment.
  - clear_stats does not affect the pipeline.
- Multi-bit errors are not detected. The word is "corrected" per the syndrome without any further flag.

Test Plan:
- Clean word: in_code=7'b1010101, syndrome=3'b000, out_ready=1 -> 2 cycles later out_code=7'b1010101, out_data=4'b1011, err_pos=0, err_flag=0, word_count=1, err_count=0.
- Single error: in_code=7'b1000101, syndrome=3'b101 -> out_code=7'b1010101, out_data=4'b1011, err_pos=5, err_flag=1, err_count=1.
- Every syndrome: sweep all 7 single-bit flips of 7'b1010101 -> the corrected code is always 7'b1010101 and err_pos matches the flipped index+1. Stream back-to-back with in_valid=1 for 8 cycles -> 8 outputs in consecutive cycles.
- Backpressure: out_ready=0 while pushing 3 words -> in_ready low after 2 accepts, outputs held stable. Release -> the words emerge in order, no loss or duplication.
- Counter saturation/clear: CNT_W=2, deliver 5 errored words -> both counters=3. Assert clear_stats together with a handshake -> both counters=0.
- Async reset: assert rst mid-stream, with no clk edge -> out_valid=0 and counters=0 immediately. After release, the first new word emerges with latency 2.
